// File: rtl/scaler_pkg.sv
// Shared definitions for the scaler / LCD buffer-RAM datapath: requester ids,
// default bus widths and the read-return pipeline entry.
package scaler_pkg;

    localparam logic REQ_LCD = 1'b0;
    localparam logic REQ_AUX = 1'b1;

    localparam int DEF_ADDR_W = 17;
    localparam int DEF_DATA_W = 16;

    typedef struct packed {
        logic valid;
        logic id;
    } ret_ent_t;

endpackage

// File: rtl/rd_lat_pipe.sv
// RD_LAT-deep shift register that tracks outstanding BRAM reads {valid, id};
// RD_LAT=0 is a pure wire for a combinational RAM.
module rd_lat_pipe
    import scaler_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    input  ret_ent_t ent_d,
    output ret_ent_t ent_q
);

    generate
        if (RD_LAT == 0) begin : g_bypass
            assign ent_q = ent_d;
        end else begin : g_pipe
            ret_ent_t stage [RD_LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < RD_LAT; i++) begin
                        stage[i] <= '0;
                    end
                end else begin
                    stage[0] <= ent_d;
                    for (int i = 1; i < RD_LAT; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign ent_q = stage[RD_LAT-1];
        end
    endgenerate

endmodule

// File: rtl/bram_rd_arbiter.sv
// Two-way arbiter for the bufferram read port: LCD scan-out (r0) versus an
// auxiliary reader (r1), with bounded r1 starvation and an r0 underrun counter.
module bram_rd_arbiter
    import scaler_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rr_mode,
    input  logic              r0_req,
    input  logic [ADDR_W-1:0] r0_addr,
    output logic              r0_gnt,
    output logic              r0_valid,
    output logic [DATA_W-1:0] r0_data,
    input  logic              r1_req,
    input  logic [ADDR_W-1:0] r1_addr,
    output logic              r1_gnt,
    output logic              r1_valid,
    output logic [DATA_W-1:0] r1_data,
    input  logic              r0_miss_clr,
    output logic [7:0]        r0_miss_cnt,
    output logic [ADDR_W-1:0] BRAMADDR,
    input  logic [DATA_W-1:0] BRAMDATA
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic              rdy;
    logic [7:0]        starve_cnt;
    logic              last_gnt;
    logic [ADDR_W-1:0] addr_q;
    ret_ent_t          ret_d;
    ret_ent_t          ret_q;

    // Handshake: a read transfers in any cycle with req && gnt. A requester
    // keeps req/addr stable until granted and may drop req to withdraw.
    always_comb begin
        r0_gnt = 1'b0;
        r1_gnt = 1'b0;
        if (rdy) begin
            if (r0_req && !r1_req) begin
                r0_gnt = 1'b1;
            end else if (r1_req && !r0_req) begin
                r1_gnt = 1'b1;
            end else if (r0_req && r1_req) begin
                if (starve_cnt == STARVE_LIM) begin
                    r1_gnt = 1'b1;
                end else if (!rr_mode || last_gnt == REQ_AUX) begin
                    r0_gnt = 1'b1;
                end else begin
                    r1_gnt = 1'b1;
                end
            end
        end
    end

    always_comb begin
        BRAMADDR = addr_q;
        if (r0_gnt) begin
            BRAMADDR = r0_addr;
        end else if (r1_gnt) begin
            BRAMADDR = r1_addr;
        end
        ret_d.valid = r0_gnt || r1_gnt;
        ret_d.id    = r1_gnt ? REQ_AUX : REQ_LCD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy        <= 1'b0;
            starve_cnt <= '0;
            last_gnt   <= REQ_AUX;
            addr_q     <= '0;
        end else begin
            rdy <= 1'b1;
            if (r1_req && !r1_gnt) begin
                if (starve_cnt < STARVE_LIM) begin
                    starve_cnt <= starve_cnt + 8'd1;
                end
            end else begin
                starve_cnt <= '0;
            end
            if (r0_gnt || r1_gnt) begin
                last_gnt <= r1_gnt ? REQ_AUX : REQ_LCD;
                addr_q   <= BRAMADDR;
            end
        end
    end

    // Underrun only counts once the arbiter is live; clear beats increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0_miss_cnt <= '0;
        end else if (r0_miss_clr) begin
            r0_miss_cnt <= '0;
        end else if (r0_req && !r0_gnt && rdy && r0_miss_cnt != 8'hFF) begin
            r0_miss_cnt <= r0_miss_cnt + 8'd1;
        end
    end

    rd_lat_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_lat_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .ent_d (ret_d),
        .ent_q (ret_q)
    );

    assign r0_valid = ret_q.valid && (ret_q.id == REQ_LCD);
    assign r1_valid = ret_q.valid && (ret_q.id == REQ_AUX);
    assign r0_data  = BRAMDATA;
    assign r1_data  = BRAMDATA;

endmodule

// File: tb/tb_bram_rd_arbiter.sv
// Bench for bram_rd_arbiter: three instances (RD_LAT 1, 3, 0) share stimulus;
// a per-instance queue predicts every read return.
module tb_bram_rd_arbiter;

  localparam int SB_W = 49;  // {due cycle[31:0], id, data[15:0]}

  typedef struct {
    logic        r0q;
    logic        r1q;
    logic        rr;
    logic        eg0;
    logic        eg1;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rr_mode;
  logic        r0_req;
  logic [16:0] r0_addr;
  logic        r1_req;
  logic [16:0] r1_addr;
  logic        r0_miss_clr;

  logic        a_r0_gnt, a_r1_gnt, a_r0_valid, a_r1_valid;
  logic [15:0] a_r0_data, a_r1_data, a_dat;
  logic [7:0]  a_miss;
  logic [16:0] a_addr;
  logic        b_r0_gnt, b_r1_gnt, b_r0_valid, b_r1_valid;
  logic [15:0] b_r0_data, b_r1_data, b_dat;
  logic [7:0]  b_miss;
  logic [16:0] b_addr, b_ad1, b_ad2;
  logic        c_r0_gnt, c_r1_gnt, c_r0_valid, c_r1_valid;
  logic [15:0] c_r0_data, c_r1_data, c_dat;
  logic [7:0]  c_miss;
  logic [16:0] c_addr;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;

  logic [SB_W-1:0] q_a[$];
  logic [SB_W-1:0] q_b[$];
  logic [SB_W-1:0] q_c[$];

  logic [16:0] exp_addr;
  int          exp_miss;
  logic        exp_rdy;
  vec_t        vecs[14];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- memory models ----------------
  function automatic logic [15:0] mem_f(input logic [16:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C ^ {15'b0, a[16]};
  endfunction

  always @(posedge clk) a_dat <= mem_f(a_addr);
  always @(posedge clk) begin
    b_ad1 <= b_addr;
    b_ad2 <= b_ad1;
    b_dat <= mem_f(b_ad2);
  end
  assign c_dat = mem_f(c_addr);

  // ---------------- DUTs ----------------
  bram_rd_arbiter #(.ADDR_W(17), .DATA_W(16), .RD_LAT(1), .STARVE_MAX(8)) u_a (
    .clk(clk), .rst_n(rst_n), .rr_mode(rr_mode),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_gnt(a_r0_gnt),
    .r0_valid(a_r0_valid), .r0_data(a_r0_data),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_gnt(a_r1_gnt),
    .r1_valid(a_r1_valid), .r1_data(a_r1_data),
    .r0_miss_clr(r0_miss_clr), .r0_miss_cnt(a_miss),
    .BRAMADDR(a_addr), .BRAMDATA(a_dat)
  );

  bram_rd_arbiter #(.ADDR_W(17), .DATA_W(16), .RD_LAT(3), .STARVE_MAX(8)) u_b (
    .clk(clk), .rst_n(rst_n), .rr_mode(rr_mode),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_gnt(b_r0_gnt),
    .r0_valid(b_r0_valid), .r0_data(b_r0_data),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_gnt(b_r1_gnt),
    .r1_valid(b_r1_valid), .r1_data(b_r1_data),
    .r0_miss_clr(r0_miss_clr), .r0_miss_cnt(b_miss),
    .BRAMADDR(b_addr), .BRAMDATA(b_dat)
  );

  bram_rd_arbiter #(.ADDR_W(17), .DATA_W(16), .RD_LAT(0), .STARVE_MAX(8)) u_c (
    .clk(clk), .rst_n(rst_n), .rr_mode(rr_mode),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_gnt(c_r0_gnt),
    .r0_valid(c_r0_valid), .r0_data(c_r0_data),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_gnt(c_r1_gnt),
    .r1_valid(c_r1_valid), .r1_data(c_r1_data),
    .r0_miss_clr(r0_miss_clr), .r0_miss_cnt(c_miss),
    .BRAMADDR(c_addr), .BRAMDATA(c_dat)
  );

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic check_ret(input int k, input logic v0, input logic v1,
                           input logic [15:0] d0, input logic [15:0] d1, input string name);
    logic [SB_W-1:0] e;
    logic            has;
    if (!(v0 || v1)) return;
    has = 1'b0;
    e = '0;
    case (k)
      0: if (q_a.size() > 0) begin e = q_a.pop_front(); has = 1'b1; end
      1: if (q_b.size() > 0) begin e = q_b.pop_front(); has = 1'b1; end
      default: if (q_c.size() > 0) begin e = q_c.pop_front(); has = 1'b1; end
    endcase
    chk({name, "_single_valid"}, {31'b0, v0 && v1}, 32'd0);
    chk({name, "_expected_return"}, {31'b0, has}, 32'd1);
    if (has) begin
      chk({name, "_id"}, {31'b0, v1}, {31'b0, e[16]});
      chk({name, "_data"}, {16'b0, v1 ? d1 : d0}, {16'b0, e[15:0]});
      chk({name, "_due_cycle"}, cyc_n, e[48:17]);
    end
  endtask

  always @(negedge clk) begin
    #2;
    check_ret(0, a_r0_valid, a_r1_valid, a_r0_data, a_r1_data, "lat1_ret");
    check_ret(1, b_r0_valid, b_r1_valid, b_r0_data, b_r1_data, "lat3_ret");
    check_ret(2, c_r0_valid, c_r1_valid, c_r0_data, c_r1_data, "lat0_ret");
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; checks at the falling edge, returns after the next rising edge.
  task automatic cyc(input logic r0q, input logic r1q, input logic [16:0] a0, input logic [16:0] a1,
                     input logic rr, input logic clr, input logic eg0, input logic eg1, input string name);
    logic [16:0] ea;
    logic [15:0] ed;
    r0_req = r0q; r1_req = r1q; r0_addr = a0; r1_addr = a1;
    rr_mode = rr; r0_miss_clr = clr;
    ea = eg0 ? a0 : (eg1 ? a1 : exp_addr);
    ed = mem_f(ea);
    @(negedge clk);
    chk({name, "_r0_gnt"}, {31'b0, a_r0_gnt}, {31'b0, eg0});
    chk({name, "_r1_gnt"}, {31'b0, a_r1_gnt}, {31'b0, eg1});
    chk({name, "_lat0_gnt"}, {30'b0, c_r1_gnt, c_r0_gnt}, {30'b0, eg1, eg0});
    chk({name, "_bramaddr"}, {15'b0, a_addr}, {15'b0, ea});
    chk({name, "_miss"}, {24'b0, a_miss}, exp_miss);
    chk({name, "_lat0_miss"}, {24'b0, c_miss}, exp_miss);
    if (eg0 || eg1) begin
      q_a.push_back({32'(cyc_n + 1), eg1, ed});
      q_b.push_back({32'(cyc_n + 3), eg1, ed});
      q_c.push_back({32'(cyc_n), eg1, ed});
    end
    exp_addr = ea;
    if (clr) exp_miss = 0;
    else if (r0q && !eg0 && exp_rdy && exp_miss < 255) exp_miss++;
    exp_rdy = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n, input logic r0q);
    r0_req = r0q; r1_req = 1'b0; r0_addr = 17'h0AA; r1_addr = '0;
    rr_mode = 1'b0; r0_miss_clr = 1'b0;
    rst_n = 1'b0;
    q_a.delete(); q_b.delete(); q_c.delete();
    exp_addr = '0; exp_miss = 0; exp_rdy = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_gnt", {26'b0, a_r0_gnt, a_r1_gnt, b_r0_gnt, b_r1_gnt, c_r0_gnt, c_r1_gnt}, 32'd0);
      chk("rst_valid", {26'b0, a_r0_valid, a_r1_valid, b_r0_valid, b_r1_valid, c_r0_valid, c_r1_valid}, 32'd0);
      chk("rst_bramaddr", {15'b0, a_addr | b_addr | c_addr}, 32'd0);
      chk("rst_miss", {8'b0, a_miss, b_miss, c_miss}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};  // rdy not yet set
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};  // first tie after reset goes to r0
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};  // lone r1
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};  // lone r0
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};  // fixed priority
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};  // back to rr: last was r0
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};  // idle holds address
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; rr_mode = 1'b0; r0_req = 1'b0; r1_req = 1'b0;
    r0_addr = '0; r1_addr = '0; r0_miss_clr = 1'b0;
    @(posedge clk);
    #1;

    // Reset release with r0 already requesting.
    do_reset(2, 1'b1);
    cyc(1, 0, 17'h0AA, 0, 0, 0, 0, 0, "rel_first");
    cyc(1, 0, 17'h0AA, 0, 0, 0, 1, 0, "rel_second");

    // Single requester streaming.
    for (int i = 0; i < 10; i++) cyc(1, 0, 17'(i), 0, 0, 0, 1, 0, "stream");
    for (int i = 0; i < 4; i++) cyc(0, 0, 17'h1FFFF, 0, 0, 0, 0, 0, "idle");

    // Fixed priority: r1 forced every 9th cycle.
    for (int k = 0; k < 18; k++)
      cyc(1, 1, 17'(17'h100 + k), 17'(17'h200 + k), 0, 0, (k % 9) != 8, (k % 9) == 8, "starve");

    // Reset with three reads in flight.
    for (int k = 0; k < 3; k++) cyc(1, 0, 17'(17'h50 + k), 0, 0, 0, 1, 0, "inflight");
    do_reset(3, 1'b0);

    // Round-robin and mixed patterns.
    for (int i = 0; i < 14; i++)
      cyc(vecs[i].r0q, vecs[i].r1q, 17'(17'h300 + i), 17'(17'h400 + i),
          vecs[i].rr, 0, vecs[i].eg0, vecs[i].eg1, "table");

    // 300 r0 misses under round-robin: counter saturates at 255.
    for (int k = 0; k <= 600; k++)
      cyc(1, 1, 17'(17'h1000 + k / 2), 17'(17'h2000 + k / 2), 1, 0, (k % 2) == 0, (k % 2) == 1, "sat");
    chk("sat_model_255", exp_miss, 32'd255);
    cyc(1, 1, 17'h1200, 17'h3000, 1, 1, 0, 1, "clr_on_miss");
    cyc(1, 0, 17'h1200, 17'h3000, 1, 0, 1, 0, "after_clr");
    chk("after_clr_miss", {24'b0, a_miss}, 32'd0);

    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, "drain");
    chk("lat1_queue_empty", q_a.size(), 32'd0);
    chk("lat3_queue_empty", q_b.size(), 32'd0);
    chk("lat0_queue_empty", q_c.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
